// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and FSM state type for the mux scan controller.
// Channel count and select width are fixed by the downstream 8:1 mux.
package mux_scan_ctrl_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // First channel visited for a given scan order.
    function automatic logic [SEL_W-1:0] first_sel(input logic dir);
        return dir ? SEL_W'(NUM_CH - 1) : '0;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller, its requester/consumer and the external mux.
// slave = controller view, master = environment view.
interface mux_scan_ctrl_if;
    import mux_scan_ctrl_pkg::*;

    logic              start;
    logic              dir;
    logic              y;
    logic [SEL_W-1:0]  sel;
    logic              busy;
    logic [NUM_CH-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport slave (
        input  start, dir, y, data_ready,
        output sel, busy, data_out, data_valid
    );

    modport master (
        output start, dir, y, data_ready,
        input  sel, busy, data_out, data_valid
    );

endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks sel across all mux channels, assembling the returned bits into a word
// that is published with a valid/ready handshake once all channels are sampled.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [SEL_W-1:0]  cnt_reg, cnt_next;
    logic              dir_reg, dir_next;
    logic [NUM_CH-1:0] shadow_reg, shadow_next;
    logic [NUM_CH-1:0] word_reg, word_next;
    logic              valid_reg, valid_next;
    logic [NUM_CH-1:0] shadow_upd;

    // Shadow with the current channel's bit replaced by y; used both for the
    // running shadow and for the final word so the last sample is included.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shadow
            assign shadow_upd[gi] = (sel_reg == SEL_W'(gi)) ? bus.y : shadow_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        cnt_next    = cnt_reg;
        dir_next    = dir_reg;
        shadow_next = shadow_reg;
        word_next   = word_reg;
        valid_next  = valid_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    dir_next   = bus.dir;
                    sel_next   = first_sel(bus.dir);
                    cnt_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                shadow_next = shadow_upd;
                cnt_next    = cnt_reg + SEL_W'(1);
                sel_next    = dir_reg ? (sel_reg - SEL_W'(1)) : (sel_reg + SEL_W'(1));
                if (cnt_reg == SEL_W'(NUM_CH - 1)) begin
                    word_next  = shadow_upd;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.data_ready) begin
                    valid_next = 1'b0;
                    if (bus.start) begin
                        dir_next   = bus.dir;
                        sel_next   = first_sel(bus.dir);
                        cnt_next   = '0;
                        state_next = SCAN;
                    end else begin
                        sel_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            cnt_reg    <= '0;
            dir_reg    <= 1'b0;
            shadow_reg <= '0;
            word_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            cnt_reg    <= cnt_next;
            dir_reg    <= dir_next;
            shadow_reg <= shadow_next;
            word_reg   <= word_next;
            valid_reg  <= valid_next;
        end
    end

    assign bus.sel        = sel_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.data_out   = word_reg;
    assign bus.data_valid = valid_reg;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on rising clk.
REQ-002 SHALL expose the following ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  scan request, sampled only in IDLE
- dir  input  1  scan order, latched with start: 0 = sel 0..7, 1 = sel 7..0
- y  input  1  selected bit returned by the downstream 8:1 mux (combinational from sel)
- sel  output  3  registered channel select driven to the downstream mux
- busy  output  1  high in SCAN and HOLD
- data_out  output  8  assembled word, bit i = y sampled while sel == i
- data_valid  output  1  word available
- data_ready  input  1  consumer accepts word

Function
REQ-003 SHALL implement the FSM states IDLE, SCAN and HOLD.
REQ-004 IDLE: sel = 0, busy = 0, data_valid = 0. On an edge with start = 1, SHALL latch dir, load sel = (dir ? 7 : 0), clear the 3-bit sample counter, and go to SCAN.
REQ-005 SCAN: on each edge SHALL write y into shadow bit [sel], increment the counter, and step sel by +1 (dir = 0) or -1 (dir = 1).
REQ-006 SCAN SHALL last exactly 8 edges. On the 8th edge it SHALL copy the complete word, including the bit sampled on that edge, to data_out, set data_valid = 1, and go to HOLD.
REQ-007 Latency: with start sampled at edge N, data_valid SHALL be high after edge N+8.
REQ-008 HOLD: data_out and data_valid SHALL stay stable while data_ready = 0. sel SHALL hold its last value.
REQ-009 On an edge in HOLD with data_ready = 1, data_valid SHALL clear. The next state SHALL be SCAN if start = 1 on that edge (re-latching dir and reloading sel per REQ-004), otherwise IDLE.
REQ-010 start SHALL be ignored in SCAN, and in HOLD except as in REQ-009.
REQ-011 dir changes after the latch edge SHALL NOT affect an in-progress scan.
REQ-012 data_out SHALL retain the last word after handshake until the next word completes.
REQ-013 Internal wrap of sel (7 -> 0 or 0 -> 7) after the 8th sample SHALL have no observable effect, because REQ-004/REQ-009 reload sel.
REQ-014 The shadow register SHALL NOT be visible on data_out until a scan completes.

Reset
REQ-015 While rst = 1 at an edge, the block SHALL force state = IDLE, sel = 0, busy = 0, data_valid = 0, data_out = 8'h00, shadow = 8'h00, counter = 0, latched dir = 0.
REQ-016 rst SHALL take priority over start and data_ready.
REQ-017 A reset mid-SCAN or mid-HOLD SHALL abort and discard the partial or pending word.

Structure
REQ-018 A shared package SHALL hold NUM_CH = 8, SEL_W = 3 and the FSM state typedef (IDLE/SCAN/HOLD, 2-bit encoding).
REQ-019 The RTL SHALL be one module with no sub-modules.
REQ-020 The bench SHALL connect sel/y through the team's existing 8:1 mux with its 8-bit input driven by the testbench.

Verification
REQ-021 Mux inputs 8'hA5, dir = 0, 1-cycle start -> sel sequence 0..7 on consecutive cycles; data_valid rises after edge N+8 with data_out = 8'hA5.
REQ-022 Mux inputs 8'h3C, dir = 1 -> sel sequence 7..0; data_out = 8'h3C (bit order by index, not by time).
REQ-023 data_ready held low 5 cycles after valid -> data_out and data_valid stable for all 5 cycles; clears on the first data_ready = 1 edge; busy falls on the same edge.
REQ-024 start pulsed at the 3rd SCAN cycle, and mux inputs changed to 8'hFF after the scan ends -> no restart; the word reflects the inputs present during the scan.
REQ-025 rst asserted when sel = 3 -> next cycle sel = 0, busy = 0, data_valid = 0, data_out = 8'h00; a new start then produces a correct full word.
REQ-026 start = 1 and data_ready = 1 held continuously, with inputs 8'h81 then 8'h7E -> back-to-back words 8'h81, 8'h7E with exactly one HOLD cycle between scans.
